// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor (diff = a - b - borrow_in), LSB first, one bit per clock.
// Optional registered zero flag on diff when SERIAL_SUB_ZERO_FLAG_EN is defined.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int CNT_W = (WIDTH < 2) ? 1 : $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic             borrow_reg;
  logic [WIDTH-1:0] res_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_out_reg;

  logic             x_bit;
  logic             y_bit;
  logic             z_bit;
  logic             d_bit;
  logic             b_bit;
  logic [WIDTH-1:0] res_next;

  assign x_bit = a_sh_reg[0];
  assign y_bit = b_sh_reg[0];
  assign z_bit = borrow_reg;
  assign d_bit = x_bit ^ y_bit ^ z_bit;
  assign b_bit = (~x_bit & y_bit) | (~x_bit & z_bit) | (y_bit & z_bit);

  // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = d_bit;
    end else begin : g_res_wn
      assign res_next = {d_bit, res_reg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      a_sh_reg       <= '0;
      b_sh_reg       <= '0;
      borrow_reg     <= 1'b0;
      res_reg        <= '0;
      cnt_reg        <= '0;
      diff_reg       <= '0;
      borrow_out_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg  <= SHIFT;
            a_sh_reg   <= a;
            b_sh_reg   <= b;
            borrow_reg <= borrow_in;
            cnt_reg    <= '0;
          end
        end
        SHIFT: begin
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          borrow_reg <= b_bit;
          res_reg    <= res_next;
          cnt_reg    <= cnt_reg + 1'b1;
          // The final bit is folded into the outputs on the same edge that enters DONE.
          if (cnt_reg == LAST_BIT) begin
            state_reg      <= DONE;
            diff_reg       <= res_next;
            borrow_out_reg <= b_bit;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic zero_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_reg <= 1'b0;
    end else if (state_reg == SHIFT && cnt_reg == LAST_BIT) begin
      zero_reg <= (res_next == '0);
    end
  end

  assign zero = zero_reg;
`endif

  assign ready      = (state_reg == IDLE);
  assign busy       = (state_reg == SHIFT);
  assign done       = (state_reg == DONE);
  assign diff       = diff_reg;
  assign borrow_out = borrow_out_reg;

endmodule
